// File: rtl/systolic_edge_feeder.sv
// Edge operand feeder: buffers a ROWS x DEPTH tile and streams it with diagonal skew.
// Optional macro FEEDER_STALL_CNT_EN adds a saturating stall_count output.
module systolic_edge_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_we,
    input  logic [$clog2(ROWS)-1:0]          load_row,
    input  logic [$clog2(DEPTH)-1:0]         load_col,
    input  logic [DATA_WIDTH-1:0]            load_data,
    input  logic                             start,
    input  logic                             pause,
    output logic [ROWS*DATA_WIDTH-1:0]       feed_out,
    output logic [ROWS-1:0]                  feed_valid,
    output logic                             busy,
    output logic                             done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_count
`endif
);

    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(DEPTH);
    localparam int TW     = $clog2(ROWS + DEPTH);
    localparam int NBEATS = DEPTH + ROWS - 1;

    typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

    state_t                       state;
    logic [TW-1:0]                t;
    logic [DATA_WIDTH-1:0]        tile_mem [ROWS][DEPTH];
    logic [ROWS*DATA_WIDTH-1:0]   beat_data;
    logic [ROWS-1:0]              beat_valid;
    logic                         wr_en;

    assign wr_en = load_we && (state == IDLE)
                && ({1'b0, load_row} < (RW + 1)'(ROWS))
                && ({1'b0, load_col} < (CW + 1)'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < DEPTH; c++)
                    tile_mem[r][c] <= '0;
        end else if (wr_en) begin
            tile_mem[load_row][load_col] <= load_data;
        end
    end

    // Lane r sees column t-r; the borrow bit of diff flags t < r.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            logic [TW:0] diff;
            assign diff           = {1'b0, t} - (TW + 1)'(gi);
            assign beat_valid[gi] = !diff[TW] && (diff < (TW + 1)'(DEPTH));
            assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                beat_valid[gi] ? tile_mem[gi][diff[CW-1:0]] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            t          <= '0;
            feed_out   <= '0;
            feed_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FEED;
                        t     <= '0;
                    end
                end
                FEED: begin
                    if (!pause) begin
                        feed_out   <= beat_data;
                        feed_valid <= beat_valid;
                        if (t == TW'(NBEATS - 1))
                            state <= DONE;
                        else
                            t <= t + 1'b1;
                    end
                end
                DONE: begin
                    if (!pause) begin
                        feed_out   <= '0;
                        feed_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (state == IDLE && start)
            stall_count <= '0;
        else if (state != IDLE && pause && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder with hand-computed beat tables (ROWS=DEPTH=4).
module tb_systolic_edge_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [1:0]  load_row;
    logic [1:0]  load_col;
    logic [15:0] load_data;
    logic        start;
    logic        pause;
    logic [63:0] feed_out;
    logic [3:0]  feed_valid;
    logic        busy;
    logic        done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    systolic_edge_feeder #(.DATA_WIDTH(16), .ROWS(4), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_we    (load_we),
        .load_row   (load_row),
        .load_col   (load_col),
        .load_data  (load_data),
        .start      (start),
        .pause      (pause),
        .feed_out   (feed_out),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat table for tile buf[r][k] = 0x0100*r + k, lanes packed {3,2,1,0}.
    function automatic logic [63:0] exp_beat(input int t);
        case (t)
            0: return 64'h0000_0000_0000_0000;
            1: return 64'h0000_0000_0100_0001;
            2: return 64'h0000_0200_0101_0002;
            3: return 64'h0300_0201_0102_0003;
            4: return 64'h0301_0202_0103_0000;
            5: return 64'h0302_0203_0000_0000;
            6: return 64'h0303_0000_0000_0000;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_valid(input int t);
        case (t)
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0111;
            3: return 4'b1111;
            4: return 4'b1110;
            5: return 4'b1100;
            6: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_beat(input int t, input bit zeros);
        logic [63:0] want;
        want = zeros ? 64'h0 : exp_beat(t);
        check_val($sformatf("beat%0d data", t), feed_out, want);
        check_val($sformatf("beat%0d valid", t), {60'h0, feed_valid}, {60'h0, exp_valid(t)});
        check_val($sformatf("beat%0d done", t), {63'h0, done}, {63'h0, t == 6});
    endtask

    // Accept start, then walk beats 0..last_t. Optional pause after hold_t,
    // pause in DONE, and a start+write injection while busy after inject_t.
    task automatic stream(input int last_t, input int hold_t, input int hold_n,
                          input int done_hold, input int inject_t, input bit zeros);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("accept busy", {63'h0, busy}, 64'h1);
        check_val("accept valid", {60'h0, feed_valid}, 64'h0);
        for (int t = 0; t <= last_t; t++) begin
            tick();
            start   = 1'b0;
            load_we = 1'b0;
            check_beat(t, zeros);
            if (t == hold_t) begin
                pause = 1'b1;
                for (int i = 0; i < hold_n; i++) begin
                    tick();
                    check_beat(t, zeros);
                end
                pause = 1'b0;
            end
            if (t == inject_t) begin
                start     = 1'b1;
                load_we   = 1'b1;
                load_row  = 2'd0;
                load_col  = 2'd0;
                load_data = 16'hBEEF;
            end
            if (t == 6 && done_hold > 0) begin
                pause = 1'b1;
                for (int i = 0; i < done_hold; i++) begin
                    tick();
                    check_beat(6, zeros);
                end
                pause = 1'b0;
            end
        end
        if (last_t == 6) begin
            tick();
            check_val("end busy", {63'h0, busy}, 64'h0);
            check_val("end done", {63'h0, done}, 64'h0);
            check_val("end data", feed_out, 64'h0);
            check_val("end valid", {60'h0, feed_valid}, 64'h0);
        end
    endtask

    initial begin
        reset = 1'b1; load_we = 1'b0; load_row = '0; load_col = '0;
        load_data = '0; start = 1'b0; pause = 1'b0;
        #12;
        check_val("reset data", feed_out, 64'h0);
        check_val("reset valid", {60'h0, feed_valid}, 64'h0);
        check_val("reset busy", {63'h0, busy}, 64'h0);
        check_val("reset done", {63'h0, done}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                load_we = 1'b1; load_row = 2'(r); load_col = 2'(k);
                load_data = 16'(16'h0100 * r + k);
                tick();
            end
        load_we = 1'b0;

        // 1: plain stream
        stream(6, -1, 0, 0, -1, 1'b0);

        // 2: pauses mid-stream and in DONE
        stream(6, 2, 3, 2, -1, 1'b0);
`ifdef FEEDER_STALL_CNT_EN
        check_val("stall_count", {48'h0, stall_count}, 64'd5);
`endif

        // 3: start and write while busy are ignored
        stream(6, -1, 0, 0, 1, 1'b0);
        stream(6, -1, 0, 0, -1, 1'b0);

        // 4: asynchronous reset at beat 4
        stream(4, -1, 0, 0, -1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("async rst data", feed_out, 64'h0);
        check_val("async rst valid", {60'h0, feed_valid}, 64'h0);
        check_val("async rst busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        stream(6, -1, 0, 0, -1, 1'b1);

        // 5: load and start on the same edge
        load_we = 1'b1; load_row = 2'd1; load_col = 2'd0; load_data = 16'h1234;
        start = 1'b1;
        tick();
        load_we = 1'b0; start = 1'b0;
        tick();
        check_val("same-edge beat0", feed_out, 64'h0);
        tick();
        check_val("same-edge beat1 data", feed_out, 64'h0000_0000_1234_0000);
        check_val("same-edge beat1 valid", {60'h0, feed_valid}, 64'h3);
        begin
            int budget = 20;
            while (busy && budget > 0) begin
                tick();
                budget--;
            end
            check_val("drain idle", {63'h0, busy}, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
